dsp_ahb_interconnect: RTL and testbench

Parametrised AHB-Lite address decoder, response multiplexer and default slave for the DSP subsystem register space. It sits behind the subsystem's AHB sync bridge and fans out to NSLV DSP-module register slaves (AGC, CIC, compensation FIRs, FFT window, prominence, spectrum buffer, …). It replaces a fixed decoder and external mux with one block. That block adds:
- a generic slave count and select field;
- a protocol-correct two-cycle ERROR response for unmapped addresses;
- error capture (address, count, interrupt pulse) for firmware debug.

---
 rtl/dsp_ahb_interconnect.sv | 134 +++++++++++++
 tb/tb_dsp_ahb_interconnect.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_ahb_interconnect.sv
// AHB-Lite address decoder, response multiplexer and default slave for the
// DSP subsystem register space. Unmapped active transfers get a two-cycle
// ERROR response and are recorded for firmware debug.
module dsp_ahb_interconnect #(
  parameter int NSLV            = 8,
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int SEL_LSB         = 16,
  parameter int SEL_W           = 8,
  parameter int BASE_ID         = 1,
  parameter int ERR_ON_UNMAPPED = 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel_s,
  input  logic [AW-1:0]      haddr_s,
  input  logic [1:0]         htrans_s,
  input  logic               hwrite_s,
  input  logic               hready_s,
  output logic [DW-1:0]      hrdata_s,
  output logic               hreadyout_s,
  output logic               hresp_s,
  output logic [NSLV-1:0]    hsel_m,
  input  logic [NSLV-1:0]    hreadyout_m,
  input  logic [NSLV-1:0]    hresp_m,
  input  logic [NSLV*DW-1:0] hrdata_m,
  output logic [AW-1:0]      err_addr,
  output logic               err_write,
  output logic [15:0]        err_cnt,
  output logic               err_irq
);

  localparam int   IW     = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic ERR_EN = (ERR_ON_UNMAPPED != 0);

  // The highest slave id must fit in the select field.
  if ((BASE_ID + NSLV - 1) >= (2 ** SEL_W)) begin : g_bad_map
    $error("dsp_ahb_interconnect: BASE_ID+NSLV-1 does not fit in SEL_W bits");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_field;
  logic             any_match;
  logic [IW-1:0]    match_idx;
  logic             unmapped_act;
  logic             err_trig;
  logic             dp_hit, dp_err;
  logic [IW-1:0]    dp_slv;
  logic             unused_htrans0;

  assign sel_field      = haddr_s[SEL_LSB +: SEL_W];
  assign unused_htrans0 = htrans_s[0];
  assign unmapped_act   = hsel_s & htrans_s[1] & ~any_match;
  assign err_trig       = hready_s & unmapped_act & ERR_EN;

  // Address-phase decode: one-hot slave select, combinational from the bus.
  always_comb begin
    hsel_m    = '0;
    any_match = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_field == SEL_W'(BASE_ID + i)) begin
        hsel_m[i] = hsel_s;
        any_match = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  // Data-phase control, advanced only when the bus accepts a new address.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_hit <= 1'b0;
      dp_err <= 1'b0;
    end else if (hready_s) begin
      dp_hit <= hsel_s & any_match;
      dp_err <= unmapped_act & ERR_EN;
    end
  end

  // Data-phase slave index; only meaningful while dp_hit is set.
  always_ff @(posedge hclk) begin
    if (hready_s) dp_slv <= match_idx;
  end

  // Default-slave state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Default-slave next state plus response mux towards the master.
  always_comb begin
    state_nxt   = state;
    hrdata_s    = '0;
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    err_irq     = dp_err && (state == ST_ERR1);
    case (state)
      ST_IDLE: if (err_trig) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = err_trig ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (dp_hit) begin
      for (int i = 0; i < NSLV; i++) begin
        if (dp_slv == IW'(i)) begin
          hrdata_s    = hrdata_m[i*DW +: DW];
          hreadyout_s = hreadyout_m[i];
          hresp_s     = hresp_m[i];
        end
      end
    end else begin
      hreadyout_s = !(dp_err && (state == ST_ERR1));
      hresp_s     = dp_err && (state != ST_IDLE);
    end
  end

  // Record every accepted unmapped active transfer, count saturating.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_addr  <= '0;
      err_write <= 1'b0;
      err_cnt   <= '0;
    end else if (hready_s && unmapped_act) begin
      err_addr  <= haddr_s;
      err_write <= hwrite_s;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dsp_ahb_interconnect.sv
// Directed bench for dsp_ahb_interconnect: a decode/response vector table
// plus hand-written sequences for wait states, ERROR responses and reset.
module tb_dsp_ahb_interconnect;

  localparam int NSLV = 8;
  localparam int DW   = 32;

  logic             hclk = 1'b0;
  logic             hresetn;
  logic             hsel_s, hsel0;
  logic [31:0]      haddr_s;
  logic [1:0]       htrans_s;
  logic             hwrite_s;
  logic             hready_s, hready0;
  logic [NSLV-1:0]    hreadyout_m, hresp_m;
  logic [NSLV*DW-1:0] hrdata_m;

  logic [31:0]     hrdata_s, hrdata0;
  logic            hreadyout_s, hreadyout0, hresp_s, hresp0;
  logic [NSLV-1:0] hsel_m, hsel_m0;
  logic [31:0]     err_addr, err_addr0;
  logic            err_write, err_write0, err_irq, err_irq0;
  logic [15:0]     err_cnt, err_cnt0;

  int nvec = 0;
  int nfail = 0;

  always #5 hclk = ~hclk;

  assign hready_s = hreadyout_s;
  assign hready0  = hreadyout0;

  dsp_ahb_interconnect dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_s(hsel_s), .haddr_s(haddr_s),
    .htrans_s(htrans_s), .hwrite_s(hwrite_s), .hready_s(hready_s),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .hsel_m(hsel_m), .hreadyout_m(hreadyout_m), .hresp_m(hresp_m),
    .hrdata_m(hrdata_m), .err_addr(err_addr), .err_write(err_write),
    .err_cnt(err_cnt), .err_irq(err_irq)
  );

  dsp_ahb_interconnect #(.ERR_ON_UNMAPPED(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel_s(hsel0), .haddr_s(haddr_s),
    .htrans_s(htrans_s), .hwrite_s(hwrite_s), .hready_s(hready0),
    .hrdata_s(hrdata0), .hreadyout_s(hreadyout0), .hresp_s(hresp0),
    .hsel_m(hsel_m0), .hreadyout_m(hreadyout_m), .hresp_m(hresp_m),
    .hrdata_m(hrdata_m), .err_addr(err_addr0), .err_write(err_write0),
    .err_cnt(err_cnt0), .err_irq(err_irq0)
  );

  typedef struct {
    logic        hsel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [7:0]  exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [1:0] t, input logic w);
    hsel_s   = s;
    haddr_s  = a;
    htrans_s = t;
    hwrite_s = w;
  endtask

  task automatic chk_rsp(input string name, input logic rdy, input logic rsp, input logic irq);
    chk({name, ".ready"}, {31'd0, hreadyout_s}, {31'd0, rdy});
    chk({name, ".resp"},  {31'd0, hresp_s},     {31'd0, rsp});
    chk({name, ".irq"},   {31'd0, err_irq},     {31'd0, irq});
  endtask

  initial begin
    for (int i = 0; i < NSLV; i++) hrdata_m[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
    hreadyout_m = '1;
    hresp_m     = '0;
    hsel0       = 1'b0;
    drive(1'b1, 32'h0002_0004, 2'b10, 1'b0);
    hresetn = 1'b0;

    // Decode table: NONSEQ=2, SEQ=3, IDLE=0, BUSY=1; slave i answers field 1+i.
    vt[0] = '{1'b1, 32'h0002_0004, 2'b10, 8'h02, 32'hA5A5_0001};
    vt[1] = '{1'b1, 32'h0001_0000, 2'b10, 8'h01, 32'hA5A5_0000};
    vt[2] = '{1'b1, 32'h0008_FFFC, 2'b11, 8'h80, 32'hA5A5_0007};
    vt[3] = '{1'b0, 32'h0003_0000, 2'b10, 8'h00, 32'h0000_0000};
    vt[4] = '{1'b1, 32'h0005_0000, 2'b00, 8'h10, 32'hA5A5_0004};
    vt[5] = '{1'b1, 32'h0009_0010, 2'b00, 8'h00, 32'h0000_0000};
    vt[6] = '{1'b1, 32'h0000_0000, 2'b01, 8'h00, 32'h0000_0000};
    vt[7] = '{1'b1, 32'h0104_0000, 2'b10, 8'h08, 32'hA5A5_0003};

    // Reset state, with decode still following the inputs.
    #12;
    chk("rst.hsel_m", {24'd0, hsel_m}, 32'h02);
    chk("rst.rdata", hrdata_s, 32'h0);
    chk_rsp("rst", 1'b1, 1'b0, 1'b0);
    chk("rst.err_cnt", {16'd0, err_cnt}, 32'h0);
    chk("rst.err_addr", err_addr, 32'h0);
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    hresetn = 1'b1;

    for (int k = 0; k < 8; k++) begin
      next_cycle();
      drive(vt[k].hsel, vt[k].addr, vt[k].trans, 1'b0);
      settle();
      chk($sformatf("v%0d.hsel_m", k), {24'd0, hsel_m}, {24'd0, vt[k].exp_sel});
      next_cycle();
      drive(1'b0, 32'h0, 2'b00, 1'b0);
      settle();
      chk($sformatf("v%0d.rdata", k), hrdata_s, vt[k].exp_rdata);
      chk_rsp($sformatf("v%0d", k), 1'b1, 1'b0, 1'b0);
    end
    chk("tbl.err_cnt", {16'd0, err_cnt}, 32'h0);

    // Slave 3 inserts three wait states; the next address is held meanwhile.
    next_cycle();
    drive(1'b1, 32'h0004_0000, 2'b10, 1'b0);
    settle();
    chk("ws.hsel_m", {24'd0, hsel_m}, 32'h08);
    next_cycle();
    drive(1'b1, 32'h0002_0004, 2'b10, 1'b0);
    hreadyout_m[3] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      settle();
      chk($sformatf("ws%0d.ready", w), {31'd0, hreadyout_s}, 32'h0);
      chk($sformatf("ws%0d.rdata", w), hrdata_s, 32'hA5A5_0003);
      if (w < 2) next_cycle();
    end
    next_cycle();
    hreadyout_m[3] = 1'b1;
    settle();
    chk("ws.rel.ready", {31'd0, hreadyout_s}, 32'h1);
    chk("ws.rel.rdata", hrdata_s, 32'hA5A5_0003);
    next_cycle();
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    settle();
    chk("ws.next.rdata", hrdata_s, 32'hA5A5_0001);

    // Unmapped write: ERR1 then ERR2, capture registers updated.
    next_cycle();
    drive(1'b1, 32'h0009_0010, 2'b10, 1'b1);
    settle();
    chk("uw.hsel_m", {24'd0, hsel_m}, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    settle();
    chk_rsp("uw.err1", 1'b0, 1'b1, 1'b1);
    chk("uw.err_addr", err_addr, 32'h0009_0010);
    chk("uw.err_write", {31'd0, err_write}, 32'h1);
    chk("uw.err_cnt", {16'd0, err_cnt}, 32'h1);
    next_cycle();
    settle();
    chk_rsp("uw.err2", 1'b1, 1'b1, 1'b0);
    next_cycle();
    settle();
    chk_rsp("uw.idle", 1'b1, 1'b0, 1'b0);

    // Unmapped, unmapped, slave 0, back to back.
    next_cycle();
    drive(1'b1, 32'h0020_0000, 2'b10, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0030_0004, 2'b10, 1'b0);
    settle();
    chk_rsp("bb.a.err1", 1'b0, 1'b1, 1'b1);
    chk("bb.a.err_addr", err_addr, 32'h0020_0000);
    chk("bb.a.err_write", {31'd0, err_write}, 32'h0);
    chk("bb.a.err_cnt", {16'd0, err_cnt}, 32'h2);
    next_cycle();
    settle();
    chk_rsp("bb.a.err2", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0001_0008, 2'b10, 1'b0);
    settle();
    chk_rsp("bb.b.err1", 1'b0, 1'b1, 1'b1);
    chk("bb.b.err_addr", err_addr, 32'h0030_0004);
    chk("bb.b.err_cnt", {16'd0, err_cnt}, 32'h3);
    next_cycle();
    settle();
    chk_rsp("bb.b.err2", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    settle();
    chk_rsp("bb.s0", 1'b1, 1'b0, 1'b0);
    chk("bb.s0.rdata", hrdata_s, 32'hA5A5_0000);
    chk("bb.s0.err_cnt", {16'd0, err_cnt}, 32'h3);

    // ERR_ON_UNMAPPED=0 instance: unmapped NONSEQ read is a zero-wait OKAY.
    next_cycle();
    hsel0 = 1'b1;
    haddr_s = 32'h0009_0010; htrans_s = 2'b10; hwrite_s = 1'b0;
    next_cycle();
    hsel0 = 1'b0; htrans_s = 2'b00;
    settle();
    chk("ok0.rdata", hrdata0, 32'h0);
    chk("ok0.ready", {31'd0, hreadyout0}, 32'h1);
    chk("ok0.resp", {31'd0, hresp0}, 32'h0);
    chk("ok0.irq", {31'd0, err_irq0}, 32'h0);
    chk("ok0.err_cnt", {16'd0, err_cnt0}, 32'h1);
    chk("ok0.err_addr", err_addr0, 32'h0009_0010);

    // Asynchronous reset while in ERR1.
    next_cycle();
    drive(1'b1, 32'h00AA_0000, 2'b10, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    settle();
    chk("ar.pre.ready", {31'd0, hreadyout_s}, 32'h0);
    hresetn = 1'b0;
    #1;
    chk_rsp("ar", 1'b1, 1'b0, 1'b0);
    chk("ar.err_cnt", {16'd0, err_cnt}, 32'h0);
    next_cycle();
    hresetn = 1'b1;

    // Saturation: preload the counter, then one more unmapped transfer.
    force dut.err_cnt = 16'hFFFF;
    next_cycle();
    release dut.err_cnt;
    settle();
    chk("sat.pre", {16'd0, err_cnt}, 32'hFFFF);
    next_cycle();
    drive(1'b1, 32'h0011_0000, 2'b10, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 2'b00, 1'b0);
    settle();
    chk("sat.err_cnt", {16'd0, err_cnt}, 32'hFFFF);
    chk("sat.err_addr", err_addr, 32'h0011_0000);
    chk_rsp("sat.err1", 1'b0, 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    settle();
    chk_rsp("sat.idle", 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
